// File: rtl/tron_round_ctrl.sv
// Match/round sequencer for the two-player light-cycle game: countdown, play gating,
// crash-to-score conversion, inter-round hold and match winner.
module tron_round_ctrl #(
    parameter int WIN_SCORE   = 3,
    parameter int COUNT_TICKS = 3,
    parameter int HOLD_TICKS  = 8,
    parameter int SCORE_W     = 3,
    localparam int CD_W = ($clog2(COUNT_TICKS + 1) < 2) ? 2 : $clog2(COUNT_TICKS + 1),
    localparam int HC_W = ($clog2(HOLD_TICKS + 1) < 1) ? 1 : $clog2(HOLD_TICKS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic               crash1,
    input  logic               crash2,
    output logic               run,
    output logic               clear,
    output logic [CD_W-1:0]    countdown,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         round_result,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic               clear_q, clear_d;
    logic [CD_W-1:0]    countdown_q, countdown_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [1:0]         result_q, result_d;
    logic [1:0]         winner_q, winner_d;
    logic [HC_W-1:0]    hold_q, hold_d;
    logic [SCORE_W-1:0] score1_inc, score2_inc;

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    // Saturating increment: a score never wraps back to zero.
    assign score1_inc = (score1_q == '1) ? score1_q : score1_q + 1'b1;
    assign score2_inc = (score2_q == '1) ? score2_q : score2_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        clear_d     = 1'b0;
        countdown_d = countdown_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        result_d    = result_q;
        winner_d    = winner_q;
        hold_d      = hold_q;

        case (state_q)
            S_IDLE: begin
                countdown_d = '0;
                if (start) begin
                    state_d     = S_COUNTDOWN;
                    score1_d    = '0;
                    score2_d    = '0;
                    result_d    = 2'b00;
                    winner_d    = 2'b00;
                    countdown_d = CD_W'(COUNT_TICKS);
                    clear_d     = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (!start) begin
                    state_d     = S_IDLE;
                    countdown_d = '0;
                end else if (tick) begin
                    countdown_d = countdown_q - 1'b1;
                    if (countdown_q == CD_W'(1))
                        state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (crash1 || crash2) begin
                    state_d = S_ROUND_END;
                    hold_d  = '0;
                    if (crash1 && crash2) begin
                        result_d = 2'b11;
                    end else if (crash1) begin
                        result_d = 2'b10;
                        score2_d = score2_inc;
                        if (score2_inc == WIN_VAL) begin
                            state_d  = S_MATCH_END;
                            winner_d = 2'b10;
                        end
                    end else begin
                        result_d = 2'b01;
                        score1_d = score1_inc;
                        if (score1_inc == WIN_VAL) begin
                            state_d  = S_MATCH_END;
                            winner_d = 2'b01;
                        end
                    end
                end
            end
            S_ROUND_END: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (hold_q == HC_W'(HOLD_TICKS - 1)) begin
                        state_d     = S_COUNTDOWN;
                        hold_d      = '0;
                        countdown_d = CD_W'(COUNT_TICKS);
                        clear_d     = 1'b1;
                        result_d    = 2'b00;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            S_MATCH_END: begin
                if (!start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered so run falls on the very edge that leaves PLAY.
        run_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            clear_q     <= 1'b0;
            countdown_q <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            result_q    <= 2'b00;
            winner_q    <= 2'b00;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            clear_q     <= clear_d;
            countdown_q <= countdown_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            result_q    <= result_d;
            winner_q    <= winner_d;
            hold_q      <= hold_d;
        end
    end

    assign run          = run_q;
    assign clear        = clear_q;
    assign countdown    = countdown_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign round_result = result_q;
    assign winner       = winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_tron_round_ctrl.sv
// Directed bench for tron_round_ctrl: countdown, rounds, draw, match win, abort, reset.
module tb_tron_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       crash1 = 1'b0;
    logic       crash2 = 1'b0;
    logic       run, clear;
    logic [1:0] countdown;
    logic [2:0] score1, score2;
    logic [1:0] round_result, winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    tron_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tick         (tick),
        .crash1       (crash1),
        .crash2       (crash2),
        .run          (run),
        .clear        (clear),
        .countdown    (countdown),
        .score1       (score1),
        .score2       (score2),
        .round_result (round_result),
        .winner       (winner),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    // From ROUND_END: 8 hold ticks then 3 countdown ticks lands in PLAY.
    task automatic next_round(input string tag);
        ticks(8);
        check({tag, "_cd_state"}, state, 1);
        check({tag, "_cd_clear"}, clear, 1);
        ticks(3);
        check({tag, "_play_run"}, run, 1);
    endtask

    task automatic pulse_crash(input logic c1, input logic c2, input logic t);
        crash1 = c1;
        crash2 = c2;
        tick   = t;
        cyc();
        crash1 = 1'b0;
        crash2 = 1'b0;
        tick   = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_state", state, 0);
        check("rst_run", run, 0);
        check("rst_outs", {clear, countdown, score1, score2, round_result, winner}, 0);
        #6 reset = 1'b0;
        cyc();

        // 1. start + countdown
        start = 1'b1;
        cyc();
        check("t1_state", state, 1);
        check("t1_clear", clear, 1);
        check("t1_cd3", countdown, 3);
        cyc();
        check("t1_clear_off", clear, 0);
        check("t1_cd_hold", countdown, 3);
        ticks(1);
        check("t1_cd2", countdown, 2);
        ticks(1);
        check("t1_cd1", countdown, 1);
        check("t1_run_lo", run, 0);
        ticks(1);
        check("t1_cd0", countdown, 0);
        check("t1_state_play", state, 2);
        check("t1_run", run, 1);

        // 2. crash2 -> P1 scores
        pulse_crash(1'b0, 1'b1, 1'b0);
        check("t2_score1", score1, 1);
        check("t2_rr", round_result, 1);
        check("t2_state", state, 3);
        check("t2_run", run, 0);
        ticks(7);
        check("t2_hold7", state, 3);
        ticks(1);
        check("t2_state_cd", state, 1);
        check("t2_clear", clear, 1);
        check("t2_rr_clr", round_result, 0);
        check("t2_cd", countdown, 3);
        ticks(3);
        check("t2_play", run, 1);

        // 3. draw with same-cycle tick
        pulse_crash(1'b1, 1'b1, 1'b1);
        check("t3_rr", round_result, 3);
        check("t3_score1", score1, 1);
        check("t3_score2", score2, 0);
        check("t3_state", state, 3);
        check("t3_run", run, 0);
        next_round("t3");

        // 4. P1 takes the match
        pulse_crash(1'b0, 1'b1, 1'b0);
        check("t4_score1_2", score1, 2);
        next_round("t4a");
        pulse_crash(1'b0, 1'b1, 1'b0);
        check("t4_state", state, 4);
        check("t4_winner", winner, 1);
        check("t4_score1_3", score1, 3);
        check("t4_run", run, 0);
        pulse_crash(1'b1, 1'b0, 1'b1);
        check("t4_ignore_s2", score2, 0);
        check("t4_ignore_state", state, 4);
        start = 1'b0;
        cyc();
        check("t4_idle", state, 0);
        check("t4_keep_s1", score1, 3);
        start = 1'b1;
        cyc();
        check("t4_restart", state, 1);
        check("t4_s1_clr", score1, 0);
        check("t4_win_clr", winner, 0);

        // 5. abort beats crash1
        ticks(3);
        pulse_crash(1'b1, 1'b0, 1'b0);
        check("t5_score2", score2, 1);
        check("t5_rr", round_result, 2);
        next_round("t5");
        start  = 1'b0;
        crash1 = 1'b1;
        cyc();
        crash1 = 1'b0;
        check("t5_state", state, 0);
        check("t5_run", run, 0);
        check("t5_score2_kept", score2, 1);

        // 6. async reset mid-countdown
        start = 1'b1;
        cyc();
        ticks(1);
        check("t6_cd2", countdown, 2);
        #2 reset = 1'b1;
        #1;
        check("t6_state", state, 0);
        check("t6_outs", {run, clear, countdown, score1, score2, round_result, winner}, 0);
        #3 reset = 1'b0;
        start = 1'b0;
        cyc();
        check("t6_stay_idle", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
